// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes understood by the ALU, main-decoder
// operation classes and the funct3 values the decoder distinguishes.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_INV = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_MEM  = 2'b00,
        CLS_BR   = 2'b01,
        CLS_FUNC = 2'b10,
        CLS_RSV  = 2'b11
    } alu_class_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: main-decoder class plus funct fields to the
// 4-bit ALU operation. Also used by the single-cycle datapath.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       alu_src_i,
    output alu_op_e    alu_operation_o
);

    // Bit 30 selects subtract only for register-register forms; immediates
    // have no sub variant, so that bit belongs to the immediate there.
    always_comb begin
        alu_operation_o = ALU_INV;
        case (alu_class_e'(alu_op_i))
            CLS_MEM: alu_operation_o = ALU_ADD;
            CLS_BR:  alu_operation_o = ALU_SUB;
            CLS_FUNC: begin
                case (funct3_i)
                    F3_ADD_SUB: alu_operation_o = (funct7_5_i && !alu_src_i) ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_operation_o = ALU_AND;
                    F3_OR:      alu_operation_o = ALU_OR;
                    default:    alu_operation_o = ALU_INV;
                endcase
            end
            default: alu_operation_o = ALU_INV;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX register feeding the ALU: captures operands with write-back bypass,
// keeps held operands fresh during stalls, valid/ready handshake with flush.
module id_ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [WIDTH-1:0]      RS1_DATA,
    input  logic [WIDTH-1:0]      RS2_DATA,
    input  logic [REG_ADDR_W-1:0] RS1_ADDR,
    input  logic [REG_ADDR_W-1:0] RS2_ADDR,
    input  logic [WIDTH-1:0]      IMM,
    input  logic                  ALU_SRC,
    input  logic [1:0]            ALU_OP,
    input  logic [2:0]            FUNCT3,
    input  logic                  FUNCT7_5,
    input  logic [REG_ADDR_W-1:0] RD_ADDR,
    input  logic                  REG_WRITE,
    input  logic                  WB_WE,
    input  logic [REG_ADDR_W-1:0] WB_ADDR,
    input  logic [WIDTH-1:0]      WB_DATA,
    input  logic                  FLUSH,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [WIDTH-1:0]      A,
    output logic [WIDTH-1:0]      B,
    output logic [3:0]            ALU_OPERATION,
    output logic [REG_ADDR_W-1:0] OUT_RD_ADDR,
    output logic                  OUT_REG_WRITE
);

    logic                  valid_q, valid_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
    alu_op_e               op_q, op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic                  rw_q, rw_d, b_is_reg_q, b_is_reg_d;

    alu_op_e               dec_op;
    logic                  accept, hold, wb_live;

    alu_decoder u_dec (
        .alu_op_i        (ALU_OP),
        .funct3_i        (FUNCT3),
        .funct7_5_i      (FUNCT7_5),
        .alu_src_i       (ALU_SRC),
        .alu_operation_o (dec_op)
    );

    assign IN_READY = !valid_q || OUT_READY || FLUSH;
    assign accept   = IN_VALID && IN_READY && !FLUSH;
    assign hold     = valid_q && !OUT_READY && !FLUSH;
    assign wb_live  = WB_WE && (WB_ADDR != '0);

    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        b_is_reg_d = b_is_reg_q;
        if (FLUSH) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            a_d        = (wb_live && WB_ADDR == RS1_ADDR) ? WB_DATA : RS1_DATA;
            b_d        = ALU_SRC ? IMM : ((wb_live && WB_ADDR == RS2_ADDR) ? WB_DATA : RS2_DATA);
            op_d       = dec_op;
            rd_d       = RD_ADDR;
            rw_d       = REG_WRITE;
            rs1_d      = RS1_ADDR;
            rs2_d      = RS2_ADDR;
            b_is_reg_d = !ALU_SRC;
        end else if (hold) begin
            // A stalled entry must pick up results retiring behind it.
            if (wb_live && WB_ADDR == rs1_q) a_d = WB_DATA;
            if (wb_live && b_is_reg_q && WB_ADDR == rs2_q) b_d = WB_DATA;
        end else if (OUT_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_ADD;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            b_is_reg_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            b_is_reg_q <= b_is_reg_d;
        end
    end

    assign OUT_VALID     = valid_q;
    assign A             = a_q;
    assign B             = b_q;
    assign ALU_OPERATION = op_q;
    assign OUT_RD_ADDR   = rd_q;
    assign OUT_REG_WRITE = rw_q && valid_q;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Bench for id_ex_alu_stage: decode vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_id_ex_alu_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID, IN_READY;
    logic [31:0] RS1_DATA, RS2_DATA, IMM, WB_DATA;
    logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR, WB_ADDR;
    logic        ALU_SRC, FUNCT7_5, REG_WRITE, WB_WE, FLUSH;
    logic [1:0]  ALU_OP;
    logic [2:0]  FUNCT3;
    logic        OUT_VALID, OUT_READY, OUT_REG_WRITE;
    logic [31:0] A, B;
    logic [3:0]  ALU_OPERATION;
    logic [4:0]  OUT_RD_ADDR;

    int checks = 0;
    int errors = 0;

    // Expected architectural view of the held entry.
    logic        m_valid, m_rw, m_breg;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;

    typedef struct {
        logic [1:0] alu_op;
        logic [2:0] funct3;
        logic       f75;
        logic       alu_src;
        logic [3:0] exp_op;
    } dec_vec_t;

    dec_vec_t vecs[10];

    id_ex_alu_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
        .IMM(IMM), .ALU_SRC(ALU_SRC), .ALU_OP(ALU_OP), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
        .RD_ADDR(RD_ADDR), .REG_WRITE(REG_WRITE), .WB_WE(WB_WE), .WB_ADDR(WB_ADDR),
        .WB_DATA(WB_DATA), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .A(A), .B(B), .ALU_OPERATION(ALU_OPERATION), .OUT_RD_ADDR(OUT_RD_ADDR),
        .OUT_REG_WRITE(OUT_REG_WRITE)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] refOp(input logic [1:0] cls, input logic [2:0] f3,
                                         input logic f75, input logic src);
        if (cls == 2'b00) return 4'b0010;
        if (cls == 2'b01) return 4'b0110;
        if (cls == 2'b11) return 4'b1111;
        if (f3 == 3'b000) return (f75 && !src) ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        return 4'b1111;
    endfunction

    // Value register r holds this cycle as seen through a write-back in flight.
    function automatic logic [31:0] seenValue(input logic [4:0] r, input logic [31:0] rf);
        if (WB_WE && WB_ADDR != 5'd0 && WB_ADDR == r) return WB_DATA;
        return rf;
    endfunction

    task automatic applyIdle();
        IN_VALID = 0; RS1_DATA = 0; RS2_DATA = 0; RS1_ADDR = 0; RS2_ADDR = 0;
        IMM = 0; ALU_SRC = 0; ALU_OP = 0; FUNCT3 = 0; FUNCT7_5 = 0;
        RD_ADDR = 0; REG_WRITE = 0; WB_WE = 0; WB_ADDR = 0; WB_DATA = 0;
        FLUSH = 0; OUT_READY = 0;
    endtask

    task automatic modelReset();
        m_valid = 0; m_a = 0; m_b = 0; m_op = 4'b0010; m_rd = 0; m_rw = 0;
        m_rs1 = 0; m_rs2 = 0; m_breg = 0;
    endtask

    // One clock: check IN_READY, advance the model, check registered outputs.
    task automatic applyStimulus();
        logic        rdy, n_valid, n_rw, n_breg;
        logic [31:0] n_a, n_b;
        logic [3:0]  n_op;
        logic [4:0]  n_rd, n_rs1, n_rs2;
        #1;
        rdy = !m_valid || OUT_READY || FLUSH;
        checkOutput("in_ready", {31'd0, IN_READY}, {31'd0, rdy});
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_op = m_op; n_rd = m_rd;
        n_rw = m_rw; n_rs1 = m_rs1; n_rs2 = m_rs2; n_breg = m_breg;
        if (FLUSH) begin
            n_valid = 0;
        end else if (IN_VALID && rdy) begin
            n_valid = 1;
            n_a     = seenValue(RS1_ADDR, RS1_DATA);
            n_b     = ALU_SRC ? IMM : seenValue(RS2_ADDR, RS2_DATA);
            n_op    = refOp(ALU_OP, FUNCT3, FUNCT7_5, ALU_SRC);
            n_rd    = RD_ADDR; n_rw = REG_WRITE;
            n_rs1   = RS1_ADDR; n_rs2 = RS2_ADDR; n_breg = !ALU_SRC;
        end else if (m_valid && OUT_READY) begin
            n_valid = 0;
        end else if (m_valid) begin
            n_a = seenValue(m_rs1, m_a);
            if (m_breg) n_b = seenValue(m_rs2, m_b);
        end
        @(posedge CLK);
        #1;
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_op = n_op; m_rd = n_rd;
        m_rw = n_rw; m_rs1 = n_rs1; m_rs2 = n_rs2; m_breg = n_breg;
        checkOutput("out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
        checkOutput("out_reg_write", {31'd0, OUT_REG_WRITE}, {31'd0, m_valid && m_rw});
        if (m_valid) begin
            checkOutput("a", A, m_a);
            checkOutput("b", B, m_b);
            checkOutput("alu_operation", {28'd0, ALU_OPERATION}, {28'd0, m_op});
            checkOutput("rd_addr", {27'd0, OUT_RD_ADDR}, {27'd0, m_rd});
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
        checkOutput({tag, "_a"}, A, 32'd0);
        checkOutput({tag, "_b"}, B, 32'd0);
        checkOutput({tag, "_op"}, {28'd0, ALU_OPERATION}, 32'h2);
        checkOutput({tag, "_rd"}, {27'd0, OUT_RD_ADDR}, 32'd0);
        checkOutput({tag, "_rw"}, {31'd0, OUT_REG_WRITE}, 32'd0);
    endtask

    task automatic stallSequence(input logic src, input logic [31:0] exp_b, input string tag);
        applyIdle();
        IN_VALID = 1; OUT_READY = 1; RS2_ADDR = 7; RS2_DATA = 32'h3; ALU_SRC = src;
        IMM = 32'h1234; ALU_OP = 2'b10;
        applyStimulus();
        IN_VALID = 1; OUT_READY = 0; RS2_DATA = 32'h55; ALU_SRC = 0; IMM = 0;
        for (int c = 0; c < 3; c++) begin
            WB_WE = (c == 1); WB_ADDR = 7; WB_DATA = 32'h99;
            #1;
            checkOutput({tag, "_in_ready_low"}, {31'd0, IN_READY}, 32'd0);
            applyStimulus();
        end
        checkOutput({tag, "_b"}, B, exp_b);
        applyIdle(); OUT_READY = 1;
        applyStimulus();
    endtask

    initial begin
        vecs[0] = '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0110};
        vecs[1] = '{2'b10, 3'b000, 1'b1, 1'b1, 4'b0010};
        vecs[2] = '{2'b10, 3'b000, 1'b0, 1'b0, 4'b0010};
        vecs[3] = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000};
        vecs[4] = '{2'b10, 3'b110, 1'b0, 1'b0, 4'b0001};
        vecs[5] = '{2'b10, 3'b100, 1'b0, 1'b0, 4'b1111};
        vecs[6] = '{2'b11, 3'b000, 1'b0, 1'b0, 4'b1111};
        vecs[7] = '{2'b00, 3'b111, 1'b1, 1'b0, 4'b0010};
        vecs[8] = '{2'b01, 3'b000, 1'b0, 1'b0, 4'b0110};
        vecs[9] = '{2'b10, 3'b001, 1'b1, 1'b0, 4'b1111};

        applyIdle();
        modelReset();
        RST_N = 0;
        #12;
        checkResetState("reset");
        @(negedge CLK);
        RST_N = 1;

        for (int i = 0; i < 10; i++) begin
            applyIdle();
            IN_VALID = 1; OUT_READY = 1;
            ALU_OP = vecs[i].alu_op; FUNCT3 = vecs[i].funct3;
            FUNCT7_5 = vecs[i].f75; ALU_SRC = vecs[i].alu_src;
            applyStimulus();
            checkOutput($sformatf("decode_%0d", i), {28'd0, ALU_OPERATION}, {28'd0, vecs[i].exp_op});
        end

        applyIdle();
        IN_VALID = 1; OUT_READY = 1; RS1_ADDR = 5; RS1_DATA = 32'h11;
        WB_WE = 1; WB_ADDR = 5; WB_DATA = 32'hAA;
        applyStimulus();
        checkOutput("bypass_rs1", A, 32'hAA);
        WB_ADDR = 0;
        applyStimulus();
        checkOutput("bypass_x0", A, 32'h11);

        stallSequence(1'b0, 32'h99, "stall_reg");
        stallSequence(1'b1, 32'h1234, "stall_imm");

        applyIdle();
        IN_VALID = 1; OUT_READY = 1; RS1_ADDR = 1;
        for (int i = 0; i < 4; i++) begin
            RS1_DATA = i + 1;
            applyStimulus();
            checkOutput("b2b_valid", {31'd0, OUT_VALID}, 32'd1);
            checkOutput("b2b_a", A, i + 1);
        end

        applyIdle();
        IN_VALID = 1; OUT_READY = 0; REG_WRITE = 1; RD_ADDR = 3;
        applyStimulus();
        FLUSH = 1; RD_ADDR = 9; RS1_DATA = 32'hDEAD;
        #1;
        checkOutput("flush_in_ready", {31'd0, IN_READY}, 32'd1);
        applyStimulus();
        checkOutput("flush_valid", {31'd0, OUT_VALID}, 32'd0);
        checkOutput("flush_reg_write", {31'd0, OUT_REG_WRITE}, 32'd0);
        applyIdle();
        applyStimulus();
        checkOutput("flush_no_present", {31'd0, OUT_VALID}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            IN_VALID  = ($urandom_range(0, 9) < 7);
            OUT_READY = ($urandom_range(0, 9) < 6);
            FLUSH     = ($urandom_range(0, 19) == 0);
            RS1_ADDR  = 5'($urandom_range(0, 3));
            RS2_ADDR  = 5'($urandom_range(0, 3));
            WB_ADDR   = 5'($urandom_range(0, 3));
            WB_WE     = $urandom_range(0, 1);
            RS1_DATA  = $urandom; RS2_DATA = $urandom; IMM = $urandom; WB_DATA = $urandom;
            ALU_SRC   = $urandom_range(0, 1);
            ALU_OP    = 2'($urandom_range(0, 3));
            FUNCT3    = 3'($urandom_range(0, 7));
            FUNCT7_5  = $urandom_range(0, 1);
            RD_ADDR   = 5'($urandom_range(0, 31));
            REG_WRITE = $urandom_range(0, 1);
            applyStimulus();
        end

        applyIdle();
        IN_VALID = 1; RS1_DATA = 32'h77; RS2_DATA = 32'h88; REG_WRITE = 1; RD_ADDR = 4;
        applyStimulus();
        checkOutput("pre_reset_valid", {31'd0, OUT_VALID}, 32'd1);
        #2;
        RST_N = 0;
        #1;
        checkResetState("async_reset");
        modelReset();
        @(negedge CLK);
        RST_N = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
